sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Downstream stage of the FIFO-fed serializer. Receives the single-bit stream on ser_out, framed by piso_start and piso_done.
- Reassembles each frame into a DATA_WIDTH-bit word on prl_out with a one-cycle valid strobe.
- Detects and counts framing errors so the test environment can check the serial link end to end.

Parameters:
- DATA_WIDTH, 8, bits per serial frame and width of prl_out.
- LSB_FIRST, 1, 1: first serial bit lands in prl_out[0]; 0: first serial bit lands in prl_out[DATA_WIDTH-1].
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- ser_out  input  1  serial data bit from serializer, sampled every clk.
- piso_start  input  1  one-cycle pulse; marks the cycle carrying the first bit of a frame.
- piso_done  input  1  one-cycle pulse; marks the cycle carrying the last bit of a frame.
- prl_out  output  DATA_WIDTH  last correctly received word; holds until the next good frame.
- prl_valid  output  1  one-cycle pulse; prl_out updated this cycle.
- busy  output  1  high while a frame is in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse on any framing error.
- err_cnt  output  ERR_CNT_W  count of framing errors; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift register=0, prl_out=0, prl_valid=0, busy=0, frame_err=0, err_cnt=0. Reset mid-frame discards the partial word; no error is counted.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - piso_start=1: sample ser_out as bit 0, cnt=1, go to SHIFT.
  - piso_done=1 without piso_start: frame_err, stay in IDLE.
  - piso_start and piso_done both high: legal only if DATA_WIDTH=1 (frame completes). Otherwise frame_err, stay in IDLE.
- SHIFT: sample ser_out at bit index cnt each cycle, then cnt++.
  - Sample at cnt=DATA_WIDTH-1 with piso_done=1: good frame. Next edge loads the assembled word into prl_out, pulses prl_valid, and returns to IDLE.
  - Sample at cnt=DATA_WIDTH-1 with piso_done=0: frame_err, word discarded, go to IDLE.
  - piso_done=1 at cnt<DATA_WIDTH-1 (early end): frame_err, word discarded, go to IDLE.
  - piso_start=1 in SHIFT (restart): frame_err for the aborted frame. The current bit is taken as bit 0 of the new frame, cnt=1, stay in SHIFT.
- Bit placement:
  - LSB_FIRST=1: bit index i maps to prl_out[i].
  - LSB_FIRST=0: bit index i maps to prl_out[DATA_WIDTH-1-i].
- Latency: prl_valid and the new prl_out appear exactly 1 clk after the cycle carrying the last bit. prl_out never changes without prl_valid.
- Back-to-back frames: piso_start in the cycle right after piso_done is accepted with no gap. prl_valid of the old frame and the bit-0 sample of the new frame occur in the same cycle.
- frame_err and prl_valid are never high in the same cycle for the same frame.
  - Restart case: frame_err is asserted for the aborted frame; no prl_valid occurs for it.
- err_cnt increments by 1 per frame_err pulse and holds at 2^ERR_CNT_W-1.
- busy=1 exactly while state=SHIFT.
- Counter width is clog2(DATA_WIDTH)+1 bits; no wrap-around occurs because the counter resets to 0 or 1 on every exit from SHIFT.

Test Plan:
- Reset then idle 10 cycles -> prl_out=8'h00, prl_valid=0, busy=0, err_cnt=0 throughout.
- Send frame 8'hA5 LSB first (bits 1,0,1,0,0,1,0,1), piso_start on bit 0, piso_done on bit 7 -> one cycle later prl_out=8'hA5, prl_valid=1 for one cycle; busy high for 7 cycles.
- Back-to-back 8'h3C then 8'hC3, second piso_start in the cycle after the first piso_done -> two prl_valid pulses 8 cycles apart, values 8'h3C then 8'hC3, err_cnt=0.
- piso_done after only 5 bits of 8'hFF -> frame_err one pulse, err_cnt=1, prl_out keeps previous value, no prl_valid.
- Restart: piso_start again at bit 3, then a full 8'h81 frame -> frame_err once, err_cnt increments by 1, then prl_out=8'h81 with prl_valid.
- Assert rst at bit 4 of a frame, release, send 8'h5A -> all outputs 0 during reset, err_cnt unchanged at 0, then prl_out=8'h5A. Repeat 300 error frames -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/sipo_if.sv
// sipo_if: serial-in / parallel-out link between serializer and deserializer
interface sipo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
);
  logic                  ser_out;
  logic                  piso_start;
  logic                  piso_done;
  logic [DATA_WIDTH-1:0] prl_out;
  logic                  prl_valid;
  logic                  busy;
  logic                  frame_err;
  logic [ERR_CNT_W-1:0]  err_cnt;
  modport master (
    output ser_out, piso_start, piso_done,
    input  prl_out, prl_valid, busy, frame_err, err_cnt
  );
  modport slave (
    input  ser_out, piso_start, piso_done,
    output prl_out, prl_valid, busy, frame_err, err_cnt
  );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: reassembles framed serial bits into words and counts framing errors
module sipo_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  sipo_if.slave sif
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, idx, pos;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, word, prl_out_q, prl_out_d;
  logic                  prl_valid_q, prl_valid_d, frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  active, abort, last;
  // A start pulse always begins a fresh word at bit 0, even while shifting
  always_comb begin
    active      = sif.piso_start || state_q == SHIFT;
    abort       = sif.piso_start && state_q == SHIFT;
    idx         = sif.piso_start ? '0 : cnt_q;
    pos         = LSB_FIRST != 0 ? idx : LAST - idx;
    word        = (sif.piso_start ? '0 : sh_q) | (DATA_WIDTH'(sif.ser_out) << pos);
    last        = idx == LAST;
    state_d     = active && !last && !sif.piso_done ? SHIFT : IDLE;
    cnt_d       = state_d == SHIFT ? idx + 1'b1 : '0;
    sh_d        = state_d == SHIFT ? word : '0;
    prl_valid_d = active && last && sif.piso_done;
    prl_out_d   = prl_valid_d ? word : prl_out_q;
    frame_err_d = abort || (active ? state_d == IDLE && !prl_valid_d : sif.piso_done);
    err_cnt_d   = frame_err_d && err_cnt_q != '1 ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      prl_out_q   <= '0;
      prl_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      prl_out_q   <= prl_out_d;
      prl_valid_q <= prl_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign sif.prl_out   = prl_out_q;
  assign sif.prl_valid = prl_valid_q;
  assign sif.busy      = state_q == SHIFT;
  assign sif.frame_err = frame_err_q;
  assign sif.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed and random frames checked against a queue-based frame model
module tb_sipo_deserializer;
  localparam int DW  = 8;
  localparam int LSB = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  sipo_if #(.DATA_WIDTH(DW), .ERR_CNT_W(8)) sif ();
  sipo_deserializer #(.DATA_WIDTH(DW), .LSB_FIRST(LSB), .ERR_CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );
  always #5 clk = ~clk;
  bit          q[$];
  bit          in_frame;
  logic [DW-1:0] m_prl;
  bit          m_valid, m_err;
  int          m_cnt;
  task automatic model_reset();
    q.delete();
    in_frame = 0;
    m_prl = '0;
    m_valid = 0;
    m_err = 0;
    m_cnt = 0;
  endtask
  // Collect the frame's bits in arrival order; decide its fate when it ends
  task automatic model(input bit s, input bit st, input bit dn);
    logic [DW-1:0] w;
    m_valid = 0;
    m_err = 0;
    if (st) begin
      if (in_frame) m_err = 1;
      q = {s};
      in_frame = 1;
    end else if (in_frame) q.push_back(s);
    else if (dn) m_err = 1;
    if (in_frame && (dn || q.size() == DW)) begin
      if (dn && q.size() == DW) begin
        w = '0;
        foreach (q[i]) w[LSB != 0 ? i : DW - 1 - i] = q[i];
        m_prl = w;
        m_valid = 1;
      end else m_err = 1;
      in_frame = 0;
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("prl_out", 32'(sif.prl_out), 32'(m_prl));
    chk("prl_valid", 32'(sif.prl_valid), 32'(m_valid));
    chk("busy", 32'(sif.busy), 32'(in_frame));
    chk("frame_err", 32'(sif.frame_err), 32'(m_err));
    chk("err_cnt", 32'(sif.err_cnt), 32'(m_cnt));
  endtask
  task automatic step(input bit s, input bit st, input bit dn);
    sif.ser_out = s;
    sif.piso_start = st;
    sif.piso_done = dn;
    @(posedge clk);
    #1;
    model(s, st, dn);
    check_all();
  endtask
  task automatic send_frame(input logic [7:0] w, input int n, input bit dn);
    for (int i = 0; i < n; i++) step(w[i], i == 0, dn && i == n - 1);
  endtask
  initial begin
    int busy_cycles;
    sif.ser_out = 1'b0;
    sif.piso_start = 1'b0;
    sif.piso_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    repeat (10) step(0, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step(bit'(8'hA5 >> i), i == 0, i == 7);
      if (sif.busy) busy_cycles++;
    end
    chk("a5_value", 32'(sif.prl_out), 32'hA5);
    chk("a5_valid", 32'(sif.prl_valid), 32'd1);
    chk("a5_busy_cycles", 32'(busy_cycles), 32'd7);
    step(0, 0, 0);
    chk("a5_valid_pulse", 32'(sif.prl_valid), 32'd0);
    send_frame(8'h3C, 8, 1);
    chk("b2b_first", 32'(sif.prl_out), 32'h3C);
    send_frame(8'hC3, 8, 1);
    chk("b2b_second", 32'(sif.prl_out), 32'hC3);
    chk("b2b_err_cnt", 32'(sif.err_cnt), 32'd0);
    step(0, 0, 0);
    send_frame(8'hFF, 5, 1);
    chk("early_err", 32'(sif.frame_err), 32'd1);
    chk("early_err_cnt", 32'(sif.err_cnt), 32'd1);
    chk("early_hold", 32'(sif.prl_out), 32'hC3);
    step(0, 0, 0);
    send_frame(8'hFF, 3, 0);
    send_frame(8'h81, 1, 0);
    chk("restart_err", 32'(sif.frame_err), 32'd1);
    chk("restart_err_cnt", 32'(sif.err_cnt), 32'd2);
    for (int i = 1; i < 8; i++) step(bit'(8'h81 >> i), 0, i == 7);
    chk("restart_value", 32'(sif.prl_out), 32'h81);
    send_frame(8'hAA, 4, 0);
    sif.ser_out = 1'b0;
    sif.piso_start = 1'b0;
    sif.piso_done = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;
    check_all();
    send_frame(8'h5A, 8, 1);
    chk("post_reset_value", 32'(sif.prl_out), 32'h5A);
    chk("post_reset_err_cnt", 32'(sif.err_cnt), 32'd0);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] w = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1: send_frame(w, 8, 1);
        2: send_frame(w, $urandom_range(1, 7), 1);
        3: send_frame(w, 8, 0);
        default: send_frame(w, $urandom_range(1, 7), 0);
      endcase
      if ($urandom_range(0, 1) == 1) step(1'($urandom), 0, 0);
    end
    repeat (300) step(1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 8) == 0);
    repeat (300) step(0, 0, 1);
    chk("err_cnt_saturated", 32'(sif.err_cnt), 32'hFF);
    step(0, 0, 1);
    chk("err_cnt_holds", 32'(sif.err_cnt), 32'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
